uart_tx_sequencer: RTL
======================

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the character width in bits and the FIFO data width.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, meaning the width of the baud divisor.
REQ-003 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_w  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_enable_w  input  1  permits the start of new frames.
REQ-006 SHALL have port i_baud_div_w  input  DIV_WIDTH  bit period in clocks, minus 1.
REQ-007 SHALL have port i_fifo_empty_w  input  1  TX FIFO empty flag.
REQ-008 SHALL have port i_fifo_data_w  input  DATA_WIDTH  TX FIFO registered read data.
REQ-009 SHALL have port o_fifo_read_w  output  1  FIFO pop strobe.
REQ-010 SHALL have port o_tx_w  output  1  serial line; idles high.
REQ-011 SHALL have port o_busy_w  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port o_done_w  output  1  one-clock pulse at the end of each frame.

Function
REQ-013 SHALL implement FSM states IDLE, POP, LOAD, START, DATA and STOP.
REQ-014 SHALL transition IDLE->POP on a clock where i_enable_w=1 and i_fifo_empty_w=0; otherwise it SHALL stay in IDLE.
REQ-015 SHALL decode o_fifo_read_w from the state register as (state==POP), giving exactly one high cycle per frame with no combinational path from inputs.
REQ-016 SHALL transition POP->LOAD unconditionally, because FIFO data is valid the cycle after the pop.
REQ-017 SHALL, in LOAD, capture i_fifo_data_w into the shift register, capture i_baud_div_w into an internal divisor register, clear the bit timer, and go to START.
REQ-018 SHALL hold every bit for (captured divisor + 1) clocks; a divisor of 0 gives 1 clock per bit.
REQ-019 SHALL ignore changes to i_baud_div_w after LOAD until the next frame.
REQ-020 SHALL drive o_tx_w=0 in START, then go to DATA.
REQ-021 SHALL, in DATA, shift out DATA_WIDTH bits LSB first using a bit counter of width ceil(log2(DATA_WIDTH+1)), then go to STOP.
REQ-022 SHALL drive o_tx_w=1 in STOP, IDLE, POP and LOAD.
REQ-023 SHALL pulse o_done_w for one clock on the final clock of STOP.
REQ-024 SHALL, on the final clock of STOP, go to POP if i_enable_w=1 and i_fifo_empty_w=0, else go to IDLE (back-to-back frames).
REQ-025 SHALL, when i_enable_w deasserts mid-frame, complete the current frame and start no new one.
REQ-026 SHALL ignore i_fifo_empty_w outside IDLE and the final STOP clock; the pop is never issued when the flag is sampled high.
REQ-027 SHALL have a frame latency, from the POP cycle to the end of STOP, of 2 + (DATA_WIDTH+2)*(div+1) clocks.
REQ-028 SHALL register o_tx_w so it is glitch-free.

Reset
REQ-029 SHALL, while i_reset_w=1 and asynchronously, force state=IDLE, o_tx_w=1, o_fifo_read_w=0, o_busy_w=0, o_done_w=0, shift register=0, and bit and baud counters=0.
REQ-030 SHALL abort a frame when reset asserts mid-frame, with no pop and no o_done_w pulse; the frame byte is lost.
REQ-031 SHALL evaluate IDLE conditions on the first rising clock edge after reset deasserts.

Verification
REQ-032 SHALL verify a single byte: div=3, FIFO holds 0xA5, enable=1 -> one read pulse; o_tx_w = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; o_done_w pulses once; busy is high from POP through STOP.
REQ-033 SHALL verify back-to-back bytes: div=0, FIFO holds 0x00 then 0xFF -> two read pulses; exactly 2 idle-high clocks (POP, LOAD) between the first stop bit and the second start bit; two o_done_w pulses.
REQ-034 SHALL verify an empty FIFO: empty=1, enable=1 for 100 clocks -> o_fifo_read_w never high, o_tx_w=1, o_busy_w=0.
REQ-035 SHALL verify enable drop: enable deasserted during DATA with FIFO non-empty -> the current frame completes, with no further pop and o_busy_w=0 after STOP.
REQ-036 SHALL verify mid-frame reset: i_reset_w pulsed during the third data bit -> o_tx_w=1 and o_busy_w=0 in the same cycle, before any clock edge; no o_done_w pulse; the next byte is transmitted normally afterwards.
REQ-037 SHALL verify a divisor change: i_baud_div_w changed from 3 to 7 mid-frame -> the current frame keeps 4-clock bits and the next frame uses 8-clock bits.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops characters from a TX FIFO and serialises each
// one as a frame of start bit, DATA_WIDTH data bits (LSB first) and stop bit.
module uart_tx_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_w,
  input  logic                  i_enable_w,
  input  logic [DIV_WIDTH-1:0]  i_baud_div_w,
  input  logic                  i_fifo_empty_w,
  input  logic [DATA_WIDTH-1:0] i_fifo_data_w,
  output logic                  o_fifo_read_w,
  output logic                  o_tx_w,
  output logic                  o_busy_w,
  output logic                  o_done_w
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  bit_end_s;
  logic                  start_ok_s;

  assign bit_end_s  = (baud_q == div_q);
  assign start_ok_s = i_enable_w & ~i_fifo_empty_w;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) state_d = S_POP;
        else            state_d = S_IDLE;
      end
      // FIFO read data becomes valid one cycle after the pop strobe.
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = i_fifo_data_w;
        div_d   = i_baud_div_w;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end_s) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = S_STOP;
          else                   state_d = S_DATA;
        end else begin
          baud_d  = baud_q + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          baud_d  = '0;
          state_d = start_ok_s ? S_POP : S_IDLE;
        end else begin
          baud_d  = baud_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is computed from the next state so the flop presents it
  // in the same cycle the FSM enters each bit.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset_w) begin
    if (i_reset_w) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx_w        = tx_q;
  assign o_fifo_read_w = (state_q == S_POP);
  assign o_busy_w      = (state_q != S_IDLE);
  assign o_done_w      = (state_q == S_STOP) && bit_end_s;

endmodule
